// File: rtl/hex_display_arbiter.sv
// Two-requester arbiter for a shared four-digit hex display: captures a 16-bit value
// over req/ack, writes it one nibble per cycle, then holds ownership for HOLD_CYCLES.
module hex_display_arbiter #(
    parameter int HOLD_CYCLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_a,
    input  logic [15:0] data_a,
    input  logic        req_b,
    input  logic [15:0] data_b,
    output logic        ack_a,
    output logic        ack_b,
    output logic [3:0]  nib_out,
    output logic [3:0]  nib_we,
    output logic        owner,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_INIT =
        (HOLD_CYCLES == 0) ? '0 : CNT_W'(HOLD_CYCLES - 1);

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [15:0]        shadow_q, shadow_d;
    logic               ack_a_q, ack_a_d;
    logic               ack_b_q, ack_b_d;
    logic [3:0]         nib_out_q, nib_out_d;
    logic [3:0]         nib_we_q, nib_we_d;
    logic               owner_q, owner_d;
    logic               busy_q, busy_d;
    logic               rr_last_q, rr_last_d;

    logic               any_req;
    logic               grant_b;
    logic [1:0]         idx_nxt;

    always_comb begin
        // NOTE: every _d gets a default up front so no path through the case infers a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        hold_cnt_d = hold_cnt_q;
        shadow_d   = shadow_q;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        nib_out_d  = 4'h0;
        nib_we_d   = 4'h0;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;

        any_req = req_a || req_b;
        // On a tie the requester that did not win last time gets the display.
        grant_b = req_b && (!req_a || !rr_last_q);
        idx_nxt = idx_q + 2'd1;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    shadow_d  = grant_b ? data_b : data_a;
                    ack_a_d   = !grant_b;
                    ack_b_d   = grant_b;
                    owner_d   = grant_b;
                    rr_last_d = grant_b;
                    idx_d     = 2'd0;
                    nib_we_d  = 4'b0001;
                    nib_out_d = shadow_d[3:0];
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                if (idx_q != 2'd3) begin
                    idx_d     = idx_nxt;
                    nib_we_d  = 4'b0001 << idx_nxt;
                    nib_out_d = shadow_q[{idx_nxt, 2'b00} +: 4];
                end else if (HOLD_CYCLES == 0) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = HOLD_INIT;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            hold_cnt_q <= '0;
            shadow_q   <= 16'h0000;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            nib_out_q  <= 4'h0;
            nib_we_q   <= 4'h0;
            owner_q    <= 1'b0;
            busy_q     <= 1'b0;
            rr_last_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            hold_cnt_q <= hold_cnt_d;
            shadow_q   <= shadow_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            nib_out_q  <= nib_out_d;
            nib_we_q   <= nib_we_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
            rr_last_q  <= rr_last_d;
        end
    end

    assign ack_a   = ack_a_q;
    assign ack_b   = ack_b_q;
    assign nib_out = nib_out_q;
    assign nib_we  = nib_we_q;
    assign owner   = owner_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Scoreboard bench for hex_display_arbiter: two instances (HOLD_CYCLES 8 and 0), a timing
// model of grants, and a monitor that checks acks, nibble writes, busy and owner each cycle.
module tb_hex_display_arbiter;

    localparam int H0 = 8;
    localparam int H1 = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a   [2];
    logic        req_b   [2];
    logic [15:0] data_a  [2];
    logic [15:0] data_b  [2];
    logic        ack_a   [2];
    logic        ack_b   [2];
    logic [3:0]  nib_out [2];
    logic [3:0]  nib_we  [2];
    logic        owner   [2];
    logic        busy    [2];

    hex_display_arbiter #(.HOLD_CYCLES(H0), .CNT_W(4)) u_dut_h8 (
        .clk(clk), .rst(rst),
        .req_a(req_a[0]), .data_a(data_a[0]), .req_b(req_b[0]), .data_b(data_b[0]),
        .ack_a(ack_a[0]), .ack_b(ack_b[0]), .nib_out(nib_out[0]), .nib_we(nib_we[0]),
        .owner(owner[0]), .busy(busy[0])
    );

    hex_display_arbiter #(.HOLD_CYCLES(H1), .CNT_W(1)) u_dut_h0 (
        .clk(clk), .rst(rst),
        .req_a(req_a[1]), .data_a(data_a[1]), .req_b(req_b[1]), .data_b(data_b[1]),
        .ack_a(ack_a[1]), .ack_b(ack_b[1]), .nib_out(nib_out[1]), .nib_we(nib_we[1]),
        .owner(owner[1]), .busy(busy[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        bit          owner;
        logic [15:0] data;
        int          cyc;
    } grant_t;

    grant_t      exp_q[$];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    int          next_free [2] = '{0, 0};
    bit          rr_last   [2] = '{1'b1, 1'b1};
    logic [15:0] last_data [2] = '{16'h0, 16'h0};
    logic [3:0]  disp [2][4]   = '{default: '0};
    bit          auto_drop [2] = '{1'b1, 1'b1};
    bit          pulse_a   [2] = '{1'b0, 1'b0};
    bit          pulse_b   [2] = '{1'b0, 1'b0};

    function automatic int hold_of(input int i);
        return (i == 0) ? H0 : H1;
    endfunction

    function automatic logic [15:0] disp16(input int i);
        return {disp[i][3], disp[i][2], disp[i][1], disp[i][0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a grant happens at an edge where the display is free and someone
    // asks; the display is busy for 4 write cycles plus the hold, then free again.
    always @(posedge clk) begin
        grant_t g;
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                rr_last[i]   = 1'b1;
                next_free[i] = 0;
            end else if (cyc >= next_free[i] && (req_a[i] || req_b[i])) begin
                g.inst  = i;
                g.owner = (req_a[i] && req_b[i]) ? !rr_last[i] : req_b[i];
                g.data  = g.owner ? data_b[i] : data_a[i];
                g.cyc   = cyc;
                exp_q.push_back(g);
                rr_last[i]   = g.owner;
                last_data[i] = g.data;
                next_free[i] = cyc + 5 + hold_of(i);
            end
        end
    end

    // Downstream digit registers fed by the DUT's write port.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 4; k++)
                if (nib_we[i][k]) disp[i][k] <= nib_out[i];
    end

    grant_t cur    [2];
    bit     cur_v  [2] = '{1'b0, 1'b0};
    bit     mon_own[2] = '{1'b0, 1'b0};

    task automatic monitor_cycle(input int i);
        int         j;
        int         k;
        logic [3:0] ew;
        grant_t     g;
        if (ack_a[i] || ack_b[i]) begin
            j = -1;
            foreach (exp_q[n]) if (j < 0 && exp_q[n].inst == i) j = n;
            if (j < 0) begin
                check("ack_without_grant", {30'd0, ack_b[i], ack_a[i]}, 32'd0);
            end else begin
                g = exp_q[j];
                exp_q.delete(j);
                check("ack_owner", {30'd0, ack_b[i], ack_a[i]}, g.owner ? 32'd2 : 32'd1);
                check("ack_cycle", cyc, g.cyc);
                cur[i]     = g;
                cur_v[i]   = 1'b1;
                mon_own[i] = g.owner;
            end
        end
        ew = 4'h0;
        k  = 0;
        if (cur_v[i]) begin
            k = cyc - cur[i].cyc;
            if (k >= 0 && k < 4) ew = 4'b0001 << k;
        end
        check("nib_we", nib_we[i], ew);
        if (ew != 4'h0) check("nib_out", nib_out[i], (cur[i].data >> (4 * k)) & 16'hF);
        check("busy", busy[i], cur_v[i] && ((cyc - cur[i].cyc) <= 3 + hold_of(i)));
        check("owner", owner[i], mon_own[i]);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                cur_v[i]   = 1'b0;
                mon_own[i] = 1'b0;
                check("rst_ack", {30'd0, ack_b[i], ack_a[i]}, 32'd0);
                check("rst_nib_we", nib_we[i], 32'd0);
                check("rst_busy", busy[i], 32'd0);
                check("rst_owner", owner[i], 32'd0);
            end else begin
                monitor_cycle(i);
            end
        end
        if (!rst) exp_q.delete();
    end

    // Requester agent: one negedge step, with drop-on-ack and one-cycle pulses.
    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (auto_drop[i] && ack_a[i]) req_a[i] = 1'b0;
            if (auto_drop[i] && ack_b[i]) req_b[i] = 1'b0;
            if (pulse_a[i]) begin req_a[i] = 1'b0; pulse_a[i] = 1'b0; end
            if (pulse_b[i]) begin req_b[i] = 1'b0; pulse_b[i] = 1'b0; end
        end
    endtask

    task automatic wait_ack(input int i, input bit b, input int budget);
        bit seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            tick();
            seen = b ? ack_b[i] : ack_a[i];
        end
        if (!seen) check(b ? "ack_b_timeout" : "ack_a_timeout", b ? ack_b[i] : ack_a[i], 32'd1);
    endtask

    task automatic wait_idle(input int i, input int budget);
        for (int n = 0; n < budget && busy[i]; n++) tick();
        if (busy[i]) check("idle_timeout", busy[i], 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] snap;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_a[i] = 1'b0; req_b[i] = 1'b0; data_a[i] = 16'h0; data_b[i] = 16'h0;
        end
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // Single request from A.
        data_a[0] = 16'h1234; req_a[0] = 1'b1;
        wait_ack(0, 1'b0, 4);
        wait_idle(0, 20);
        tick();

        // Both requesters held high from reset: grants alternate.
        rst = 1'b0;
        auto_drop[0] = 1'b0;
        data_a[0] = 16'hAAAA; data_b[0] = 16'h5555;
        req_a[0] = 1'b1; req_b[0] = 1'b1;
        repeat (2) tick();
        rst = 1'b1;
        repeat (45) tick();
        req_a[0] = 1'b0; req_b[0] = 1'b0;
        auto_drop[0] = 1'b1;
        wait_idle(0, 20);
        tick();

        // B raised during A's LOAD waits for the hold to end.
        data_a[0] = 16'hC0DE; req_a[0] = 1'b1;
        wait_ack(0, 1'b0, 4);
        tick();
        data_b[0] = 16'h7E57; req_b[0] = 1'b1;
        wait_ack(0, 1'b1, 20);
        wait_idle(0, 20);
        tick();

        // Reset in LOAD cycle 2 aborts writes; only digits 0 and 1 were written.
        snap = disp16(0);
        data_a[0] = 16'hBEEF; req_a[0] = 1'b1;
        wait_ack(0, 1'b0, 4);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_nib_we", nib_we[0], 32'd0);
        check("abort_busy", busy[0], 32'd0);
        check("abort_owner", owner[0], 32'd0);
        tick();
        tick();
        check("abort_digits", disp16(0), {snap[15:8], 8'hEF});
        data_a[0] = 16'h1111; data_b[0] = 16'h2222;
        req_a[0] = 1'b1; req_b[0] = 1'b1;
        rst = 1'b1;
        wait_ack(0, 1'b0, 4);
        wait_ack(0, 1'b1, 20);
        wait_idle(0, 20);
        tick();

        // No-hold instance: B held for two back-to-back bursts.
        auto_drop[1] = 1'b0;
        data_b[1] = 16'h0F0F; req_b[1] = 1'b1;
        wait_ack(1, 1'b1, 4);
        wait_ack(1, 1'b1, 10);
        req_b[1] = 1'b0;
        auto_drop[1] = 1'b1;
        wait_idle(1, 10);
        tick();

        // One-cycle pulse from A while busy is never granted.
        data_a[0] = 16'h600D; req_a[0] = 1'b1;
        wait_ack(0, 1'b0, 4);
        tick();
        tick();
        data_a[0] = 16'hDEAD; req_a[0] = 1'b1; pulse_a[0] = 1'b1;
        tick();
        wait_idle(0, 20);
        repeat (20) tick();
        check("pulse_display", disp16(0), 16'h600D);

        // Randomized traffic on both instances.
        repeat (800) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (!req_a[i] && $urandom_range(0, 7) == 0) begin
                    data_a[i] = 16'($urandom);
                    req_a[i]  = 1'b1;
                    if ($urandom_range(0, 5) == 0) pulse_a[i] = 1'b1;
                end
                if (!req_b[i] && $urandom_range(0, 7) == 0) begin
                    data_b[i] = 16'($urandom);
                    req_b[i]  = 1'b1;
                    if ($urandom_range(0, 5) == 0) pulse_b[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            req_a[i] = 1'b0; req_b[i] = 1'b0; pulse_a[i] = 1'b0; pulse_b[i] = 1'b0;
        end
        wait_idle(0, 30);
        wait_idle(1, 30);
        repeat (5) tick();
        check("final_display_h8", disp16(0), last_data[0]);
        check("final_display_h0", disp16(1), last_data[1]);
        check("pending_grants", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
